// File: rtl/fact_calc.sv
// rtl/fact_calc.sv - iterative n! responder on a four-phase req/ack handshake
// Shift-add multiply, one multiplier bit per cycle; ovf is sticky over the whole product chain.
module fact_calc #(
   parameter int N_IN  = 7,
   parameter int N_OUT = 90
) (
   input  logic             clk,
   input  logic             RSTN,
   input  logic             req,
   input  logic [N_IN-1:0]  n,
   output logic             ack,
   output logic [N_OUT-1:0] result,
   output logic             ovf,
   output logic             busy
);

   localparam int PW = N_OUT + N_IN;
   localparam int BW = (N_IN > 1) ? $clog2(N_IN) : 1;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

   state_t           r_state;
   state_t           w_next;
   logic [N_IN-1:0]  r_n;
   logic [N_IN-1:0]  r_k;
   logic [BW-1:0]    r_bit;
   logic [N_OUT-1:0] r_acc;
   logic [N_OUT-1:0] r_result;
   logic [PW-1:0]    r_prod;
   logic             r_ack;
   logic             r_ovf;

   logic [PW-1:0]    w_addend;
   logic [PW-1:0]    w_sum;
   logic             w_small;
   logic             w_last;
   logic             w_final;

   assign w_small  = (n < N_IN'(2));
   assign w_last   = (r_bit == BW'(N_IN - 1));
   assign w_final  = w_last && (r_k == r_n);
   assign w_addend = r_k[r_bit] ? ({{N_IN{1'b0}}, r_acc} << r_bit) : '0;
   // Bit 0 starts a fresh partial product, so r_prod never needs an explicit clear.
   assign w_sum    = ((r_bit == '0) ? '0 : r_prod) + w_addend;

   always_ff @(posedge clk or negedge RSTN) begin
      if (!RSTN) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (req) w_next = w_small ? S_DONE : S_MUL;
         S_MUL: begin
            if (!req)         w_next = S_IDLE;
            else if (w_final) w_next = S_DONE;
         end
         S_DONE: if (!req) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy   = (r_state == S_MUL);
      ack    = r_ack;
      result = r_result;
      ovf    = r_ovf;
   end

   always_ff @(posedge clk or negedge RSTN) begin
      if (!RSTN) begin
         r_n      <= '0;
         r_k      <= '0;
         r_bit    <= '0;
         r_acc    <= '0;
         r_result <= '0;
         r_prod   <= '0;
         r_ack    <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (req) begin
               r_n   <= n;
               r_k   <= N_IN'(2);
               r_bit <= '0;
               r_acc <= N_OUT'(1);
               r_ovf <= 1'b0;
               if (w_small) begin
                  r_result <= N_OUT'(1);
                  r_ack    <= 1'b1;
               end
            end
            S_MUL: begin
               if (!req) begin
                  r_bit <= '0;
               end else begin
                  r_prod <= w_sum;
                  if (w_last) begin
                     r_acc <= w_sum[N_OUT-1:0];
                     r_ovf <= r_ovf | (|w_sum[PW-1:N_OUT]);
                     r_k   <= r_k + N_IN'(1);
                     r_bit <= '0;
                     if (w_final) begin
                        r_result <= w_sum[N_OUT-1:0];
                        r_ack    <= 1'b1;
                     end
                  end else begin
                     r_bit <= r_bit + BW'(1);
                  end
               end
            end
            S_DONE: if (!req) r_ack <= 1'b0;
            default: r_ack <= 1'b0;
         endcase
      end
   end

endmodule

// File: doc/fact_calc.md
FACT_CALC -- requirements
Module: fact_calc

Interface
REQ-001 SHALL have parameter N_IN, default 7, width of operand n.
REQ-002 SHALL have parameter N_OUT, default 90, width of result.
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port RSTN, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port req, input, 1, level request from the initiator.
REQ-006 SHALL have port n, input, N_IN, operand, stable while req=1.
REQ-007 SHALL have port ack, output, 1, registered completion flag.
REQ-008 SHALL have port result, output, N_OUT, n! mod 2^N_OUT, registered.
REQ-009 SHALL have port ovf, output, 1, set if true n! exceeds N_OUT bits.
REQ-010 SHALL have port busy, output, 1, high while in state MUL.

Function
REQ-011 SHALL act as responder in a four-phase level handshake: req rise -> compute -> ack=1 -> req fall -> ack=0.
REQ-012 SHALL use states IDLE, MUL, DONE.
REQ-013 IDLE with req=1 at edge T0 SHALL capture n, clear ovf, and set acc=1, k=2, bit index=0.
REQ-014 At T0, n<2 SHALL go directly to DONE with result=1 and ack=1 after the T0 edge.
REQ-015 At T0, n>=2 SHALL go to MUL.
REQ-016 MUL SHALL multiply acc by k using shift-add, one multiplier bit per cycle (bits 0..N_IN-1), with an N_OUT+N_IN-bit internal product.
REQ-017 After bit N_IN-1: acc SHALL take the low N_OUT bits of the product and k SHALL increment.
REQ-018 After bit N_IN-1: ovf SHALL set (sticky) if any product bit at or above N_OUT is 1.
REQ-019 After the multiply with k=n, the state SHALL go to DONE, and result=acc and ack=1 SHALL be visible after edge T0+(n-1)*N_IN.
REQ-020 result and ovf SHALL hold constant while ack=1 and after ack falls, until the next T0.
REQ-021 DONE with req=0 SHALL clear ack on that edge and go to IDLE.
REQ-022 DONE with req=1 SHALL hold.
REQ-023 req=0 during MUL SHALL abort: IDLE on next edge, ack stays 0, result unchanged.
REQ-024 req held 1 continuously SHALL NOT start a second computation; a new request requires req to return to 0 and rise again.
REQ-025 n SHALL be ignored except at T0; changes to n during MUL SHALL have no effect.
REQ-026 n = 2^N_IN-1 SHALL complete without hang; result is truncated and ovf=1.
REQ-027 busy SHALL equal (state==MUL); ack and busy SHALL never be 1 together.

Reset
REQ-028 RSTN=0 SHALL immediately force state=IDLE, ack=0, busy=0, ovf=0, result=0, and internal acc/k/bit=0, independent of clk.
REQ-029 RSTN asserted mid-MUL or in DONE SHALL discard the computation.
REQ-030 After RSTN release, the block SHALL wait for req=1 in IDLE; a req already high at release SHALL start a computation on the first clk edge.

Verification
REQ-031 n=0, req rise -> ack=1 after 1 edge, result=1, ovf=0; req fall -> ack=0 after next edge.
REQ-032 n=5 -> ack exactly 28 cycles after T0, result=120, ovf=0, busy high for 28 cycles.
REQ-033 n=26 -> result=403291461126605635584000000, ovf=0; then n=27 -> ovf=1, result=27! mod 2^90.
REQ-034 n=10, req dropped at T0+20 -> ack never rises, state IDLE, result keeps prior value; next req with n=3 -> result=6.
REQ-035 RSTN pulsed low at T0+10 of n=8 -> all outputs 0 immediately; req held high through release -> fresh computation, result=40320.
REQ-036 n changed from 4 to 9 at T0+3 -> result=24; req held high after ack -> no restart, ack stays 1.
